jtag2or_burst: RTL and testbench

//  Parametrised JTAG-to-oursring master bridge: decodes a scan-loaded command buffer and issues single AXI-style

---
 rtl/jtag2or_burst.sv | 201 ++++++++++++++++++++
 tb/tb_jtag2or_burst.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag2or_burst.sv
// JTAG-to-oursring master bridge: decodes a scan-loaded command buffer into single ring read/write beats,
// with auto-increment addressing, byte strobes, a response timeout and sticky error status.
`timescale 1ns/1ps
module jtag2or_burst #(
    parameter int                   ADDR_W      = 40,
    parameter int                   DATA_W      = 64,
    parameter int                   CMDBUF_W    = 128,
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'hFFFF,
    parameter int                   ID_W        = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CMDBUF_W-1:0] cmdbuf_in,
    input  logic                cmd_vld_in,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                rdata_vld_out,
    output logic [2:0]          status_out,
    output logic [ADDR_W-1:0]   or_req_if_ar_addr,
    output logic [ID_W-1:0]     or_req_if_ar_id,
    output logic                or_req_if_arvalid,
    input  logic                or_req_if_arready,
    output logic [ADDR_W-1:0]   or_req_if_aw_addr,
    output logic [ID_W-1:0]     or_req_if_aw_id,
    output logic                or_req_if_awvalid,
    input  logic                or_req_if_awready,
    output logic [DATA_W-1:0]   or_req_if_w_data,
    output logic [DATA_W/8-1:0] or_req_if_w_strb,
    output logic                or_req_if_w_last,
    output logic                or_req_if_wvalid,
    input  logic                or_req_if_wready,
    input  logic [DATA_W-1:0]   or_rsp_if_r_data,
    input  logic                or_rsp_if_rvalid,
    output logic                or_rsp_if_rready,
    input  logic                or_rsp_if_bvalid,
    output logic                or_rsp_if_bready
);
    localparam int BYTES  = DATA_W / 8;
    localparam int USED_W = 2 + ADDR_W + DATA_W + BYTES;

    typedef enum logic [2:0] {IDLE, DECODE, RREQ, RRSP, WREQ, WAIT_AW, WAIT_W, WRSP} state_t;

    state_t               state_reg, state_next;
    logic                 cmd_dly_reg;
    logic [1:0]           cmd_reg;
    logic [ADDR_W-1:0]    cur_addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [BYTES-1:0]     wstrb_reg;
    logic [DATA_W-1:0]    rdata_reg;
    logic                 rdata_vld_reg;
    logic [TIMEOUT_W-1:0] tmo_cnt_reg;
    logic                 err_overrun_reg;
    logic                 err_timeout_reg;
    logic                 ready_en_reg;

    logic                 cmd_fall, launch, in_tmo, tmo_hit, rd_done, wr_done;
    logic                 arvalid, awvalid, wvalid, rready, bready;
    logic [TIMEOUT_W-1:0] tmo_cnt_inc;
    logic [BYTES-1:0]     wstrb_eff;
    logic                 strb_zero;

    assign cmd_fall    = cmd_dly_reg && !cmd_vld_in;
    assign launch      = cmd_fall && (state_reg == IDLE);
    assign in_tmo      = (state_reg != IDLE) && (state_reg != DECODE);
    assign tmo_cnt_inc = tmo_cnt_reg + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    generate
        if (CMDBUF_W > USED_W) begin : g_spare
            logic unused_cmdbuf;
            assign unused_cmdbuf = ^cmdbuf_in[CMDBUF_W-1:USED_W];
        end
    endgenerate

    // A zero strobe field means "write every byte lane".
    assign strb_zero = (wstrb_reg == '0);
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_strb
            assign wstrb_eff[gi] = wstrb_reg[gi] | strb_zero;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        arvalid    = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        rready     = 1'b0;
        bready     = 1'b0;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        tmo_hit    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Responses arriving after an abort are drained here and dropped.
                rready = ready_en_reg;
                bready = ready_en_reg;
                if (launch) state_next = DECODE;
            end
            DECODE:  state_next = cmd_reg[0] ? WREQ : RREQ;
            RREQ: begin
                arvalid = 1'b1;
                if (or_req_if_arready) state_next = RRSP;
            end
            RRSP: begin
                rready = 1'b1;
                if (or_rsp_if_rvalid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            WREQ: begin
                awvalid = 1'b1;
                wvalid  = 1'b1;
                case ({or_req_if_awready, or_req_if_wready})
                    2'b11:   state_next = WRSP;
                    2'b10:   state_next = WAIT_W;
                    2'b01:   state_next = WAIT_AW;
                    default: state_next = WREQ;
                endcase
            end
            WAIT_AW: begin
                awvalid = 1'b1;
                if (or_req_if_awready) state_next = WRSP;
            end
            WAIT_W: begin
                wvalid = 1'b1;
                if (or_req_if_wready) state_next = WRSP;
            end
            WRSP: begin
                bready = 1'b1;
                if (or_rsp_if_bvalid) begin
                    wr_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A response landing on the final allowed cycle still counts as a completion.
        if ((TIMEOUT_CYC != '0) && in_tmo && (tmo_cnt_inc == TIMEOUT_CYC) && !rd_done && !wr_done) begin
            tmo_hit    = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            cmd_dly_reg     <= 1'b0;
            cmd_reg         <= '0;
            cur_addr_reg    <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            rdata_reg       <= '0;
            rdata_vld_reg   <= 1'b0;
            tmo_cnt_reg     <= '0;
            err_overrun_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
            ready_en_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_dly_reg  <= cmd_vld_in;
            ready_en_reg <= 1'b1;
            if (launch) begin
                cmd_reg         <= cmdbuf_in[1:0];
                wdata_reg       <= cmdbuf_in[2+ADDR_W +: DATA_W];
                wstrb_reg       <= cmdbuf_in[2+ADDR_W+DATA_W +: BYTES];
                err_overrun_reg <= 1'b0;
                err_timeout_reg <= 1'b0;
                if (!cmdbuf_in[1]) cur_addr_reg <= cmdbuf_in[2 +: ADDR_W];
            end
            if (cmd_fall && (state_reg != IDLE)) err_overrun_reg <= 1'b1;
            if (state_reg == DECODE)     tmo_cnt_reg <= '0;
            else if (in_tmo)             tmo_cnt_reg <= tmo_cnt_inc;
            if (rd_done)                 rdata_reg <= or_rsp_if_r_data;
            if (rd_done || wr_done)      cur_addr_reg <= cur_addr_reg + ADDR_W'(BYTES);
            if (tmo_hit) begin
                err_timeout_reg <= 1'b1;
                rdata_reg       <= '1;
            end
            if (rd_done || wr_done || tmo_hit) rdata_vld_reg <= 1'b1;
            else if (cmd_vld_in)               rdata_vld_reg <= 1'b0;
        end
    end

    assign rdata_out         = rdata_reg;
    assign rdata_vld_out     = rdata_vld_reg;
    assign status_out        = {err_overrun_reg, err_timeout_reg, state_reg != IDLE};
    assign or_req_if_ar_addr = cur_addr_reg;
    assign or_req_if_ar_id   = '0;
    assign or_req_if_arvalid = arvalid;
    assign or_req_if_aw_addr = cur_addr_reg;
    assign or_req_if_aw_id   = '1;
    assign or_req_if_awvalid = awvalid;
    assign or_req_if_w_data  = wdata_reg;
    assign or_req_if_w_strb  = wstrb_eff;
    assign or_req_if_w_last  = 1'b1;
    assign or_req_if_wvalid  = wvalid;
    assign or_rsp_if_rready  = rready;
    assign or_rsp_if_bready  = bready;
endmodule

// File: tb/tb_jtag2or_burst.sv
// Randomised bench for jtag2or_burst: a transaction-level address/data model plus directed corner cases.
`timescale 1ns/1ps
module tb_jtag2or_burst;
    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] cmdbuf_in;
    logic         cmd_vld_in;
    logic [63:0]  rdata_out;
    logic         rdata_vld_out;
    logic [2:0]   status_out;
    logic [39:0]  ar_addr, aw_addr;
    logic [3:0]   ar_id, aw_id;
    logic         arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic [63:0]  wdata, r_data;
    logic [7:0]   wstrb;
    logic         rvalid, rready, bvalid, bready;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: the bridge's running address and the beat it must present.
    logic [39:0] model_addr, exp_addr, cap_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb, cap_strb;
    logic [3:0]  cap_id;

    jtag2or_burst #(.ADDR_W(40), .DATA_W(64), .CMDBUF_W(128), .TIMEOUT_W(16),
                    .TIMEOUT_CYC(16'd8), .ID_W(4)) dut (
        .clk(clk), .rstn(rstn), .cmdbuf_in(cmdbuf_in), .cmd_vld_in(cmd_vld_in),
        .rdata_out(rdata_out), .rdata_vld_out(rdata_vld_out), .status_out(status_out),
        .or_req_if_ar_addr(ar_addr), .or_req_if_ar_id(ar_id),
        .or_req_if_arvalid(arvalid), .or_req_if_arready(arready),
        .or_req_if_aw_addr(aw_addr), .or_req_if_aw_id(aw_id),
        .or_req_if_awvalid(awvalid), .or_req_if_awready(awready),
        .or_req_if_w_data(wdata), .or_req_if_w_strb(wstrb), .or_req_if_w_last(wlast),
        .or_req_if_wvalid(wvalid), .or_req_if_wready(wready),
        .or_rsp_if_r_data(r_data), .or_rsp_if_rvalid(rvalid), .or_rsp_if_rready(rready),
        .or_rsp_if_bvalid(bvalid), .or_rsp_if_bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every mid-cycle, any valid beat must carry the model's payload.
    always @(negedge clk) begin
        if (rstn) begin
            if (arvalid) begin
                chk("araddr", 64'(ar_addr), 64'(exp_addr));
                chk("arid", 64'(ar_id), 64'd0);
            end
            if (awvalid) begin
                chk("awaddr", 64'(aw_addr), 64'(exp_addr));
                chk("awid", 64'(aw_id), 64'hF);
            end
            if (wvalid) begin
                chk("wdata", wdata, exp_wdata);
                chk("wstrb", 64'(wstrb), 64'(exp_wstrb));
                chk("wlast", 64'(wlast), 64'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 into cycle t+2, where t is the cycle seeing the cmd_vld_in falling edge.
    task automatic launch(input logic [1:0] cmd, input logic [39:0] addr,
                          input logic [63:0] wd, input logic [7:0] st);
        step();
        cmdbuf_in  = {14'd0, st, wd, addr, cmd};
        cmd_vld_in = 1'b1;
        step();
        chk("vld_clear", 64'(rdata_vld_out), 64'd0);
        cmd_vld_in = 1'b0;
        step();
        chk("t1_quiet", 64'({arvalid, awvalid, wvalid}), 64'd0);
        chk("t1_status", 64'(status_out), 64'd1);
        cmdbuf_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
    endtask

    // d_a >= 100 on a read means the slave never accepts the address.
    task automatic txn(input logic [1:0] cmd, input logic [39:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, input logic [63:0] rd,
                       input int d_a, input int d_w, input int d_r, input bit ovr);
        int  n;
        bit  aw_done, w_done;
        if (!cmd[1]) model_addr = addr;
        exp_addr  = model_addr;
        exp_wdata = wd;
        exp_wstrb = (st == 8'd0) ? 8'hFF : st;
        launch(cmd, addr, wd, st);
        cap_addr = cmd[0] ? aw_addr : ar_addr;
        cap_id   = cmd[0] ? aw_id : ar_id;
        cap_strb = wstrb;
        if (!cmd[0]) begin
            chk("ar_t2", 64'(arvalid), 64'd1);
            if (d_a >= 100) begin
                n = 0;
                while (arvalid && n < 20) begin
                    n++;
                    step();
                end
                chk("tmo_cycles", 64'(n), 64'd8);
                chk("tmo_status", 64'(status_out), 64'd2);
                chk("tmo_rdata", rdata_out, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("tmo_vld", 64'(rdata_vld_out), 64'd1);
                return;
            end
            repeat (d_a) begin
                chk("ar_hold", 64'(arvalid), 64'd1);
                step();
            end
            chk("ar_hold", 64'(arvalid), 64'd1);
            arready = 1'b1;
            step();
            arready = 1'b0;
            chk("ar_drop", 64'(arvalid), 64'd0);
            if (ovr) begin
                cmd_vld_in = 1'b1;
                cmdbuf_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
                step();
                cmd_vld_in = 1'b0;
                step();
                chk("ovr_status", 64'(status_out), 64'd5);
                chk("ovr_vld", 64'(rdata_vld_out), 64'd0);
            end
            repeat (d_r) begin
                chk("rready", 64'(rready), 64'd1);
                step();
            end
            chk("rready", 64'(rready), 64'd1);
            rvalid = 1'b1;
            r_data = rd;
            step();
            rvalid = 1'b0;
            chk("rdata", rdata_out, rd);
        end else begin
            aw_done = 1'b0;
            w_done  = 1'b0;
            n = 0;
            while (!(aw_done && w_done) && n < 20) begin
                chk("awvalid", 64'(awvalid), 64'(!aw_done));
                chk("wvalid", 64'(wvalid), 64'(!w_done));
                awready = !aw_done && (n >= d_a);
                wready  = !w_done && (n >= d_w);
                step();
                if (awready) aw_done = 1'b1;
                if (wready)  w_done  = 1'b1;
                awready = 1'b0;
                wready  = 1'b0;
                n++;
            end
            chk("aw_w_drop", 64'({awvalid, wvalid}), 64'd0);
            repeat (d_r) begin
                chk("bready", 64'(bready), 64'd1);
                step();
            end
            chk("bready", 64'(bready), 64'd1);
            bvalid = 1'b1;
            step();
            bvalid = 1'b0;
        end
        model_addr = model_addr + 40'd8;
        chk("done_vld", 64'(rdata_vld_out), 64'd1);
        chk("done_status", 64'(status_out), ovr ? 64'd4 : 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic [1:0]  rc;
        logic [39:0] ra;
        int          da;
        rstn = 1'b0; cmd_vld_in = 1'b0; cmdbuf_in = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; bvalid = 1'b0; r_data = '0;
        model_addr = '0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("rst_status", 64'(status_out), 64'd0);
        chk("rst_rdata", rdata_out, 64'd0);
        chk("rst_vld", 64'(rdata_vld_out), 64'd0);
        rstn = 1'b1;
        step();
        chk("idle_rdy", 64'({rready, bready}), 64'd3);

        txn(2'd0, 40'h10_0000_0000, 64'd0, 8'd0, 64'hDEADBEEF_CAFEF00D, 1, 0, 1, 1'b0);
        chk("lit_rd_addr", 64'(cap_addr), 64'h10_0000_0000);
        chk("lit_rd_data", rdata_out, 64'hDEADBEEF_CAFEF00D);

        txn(2'd1, 40'h100, 64'h1122334455667788, 8'd0, 64'd0, 0, 2, 1, 1'b0);
        chk("lit_wr_addr", 64'(cap_addr), 64'h100);
        chk("lit_wr_strb", 64'(cap_strb), 64'hFF);
        chk("lit_wr_id", 64'(cap_id), 64'hF);

        txn(2'd0, 40'h200, 64'd0, 8'd0, 64'h1, 0, 0, 0, 1'b0);
        chk("lit_inc0", 64'(cap_addr), 64'h200);
        txn(2'd2, 40'h5555, 64'd0, 8'd0, 64'h2, 2, 0, 2, 1'b0);
        chk("lit_inc1", 64'(cap_addr), 64'h208);
        txn(2'd2, 40'h7777, 64'd0, 8'd0, 64'h3, 0, 0, 1, 1'b0);
        chk("lit_inc2", 64'(cap_addr), 64'h210);

        txn(2'd2, 40'h0, 64'd0, 8'd0, 64'd0, 200, 0, 0, 1'b0);
        chk("lit_tmo_addr", 64'(cap_addr), 64'h218);
        step();
        chk("stray_rready", 64'(rready), 64'd1);
        rvalid = 1'b1;
        r_data = 64'h0123_4567_89AB_CDEF;
        step();
        rvalid = 1'b0;
        chk("stray_rdata", rdata_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stray_status", 64'(status_out), 64'd2);
        chk("stray_vld", 64'(rdata_vld_out), 64'd1);
        txn(2'd3, 40'h9999, 64'hA5A5_0000_FFFF_1234, 8'h0F, 64'd0, 1, 1, 0, 1'b0);
        chk("lit_wrinc_addr", 64'(cap_addr), 64'h218);

        txn(2'd0, 40'hFF_FFFF_FFF8, 64'd0, 8'd0, 64'h44, 0, 0, 0, 1'b0);
        txn(2'd2, 40'h1234, 64'd0, 8'd0, 64'h55, 0, 0, 0, 1'b0);
        chk("lit_wrap", 64'(cap_addr), 64'h0);

        txn(2'd0, 40'h400, 64'd0, 8'd0, 64'hBEEF, 0, 0, 0, 1'b1);
        chk("lit_ovr_addr", 64'(cap_addr), 64'h400);

        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = {8'($urandom()), 32'($urandom())};
            da = (!rc[0] && $urandom_range(0, 9) == 0) ? 200
                 : $urandom_range(0, rc[0] ? 3 : 2);
            txn(rc, ra, {$urandom(), $urandom()}, 8'($urandom()), {$urandom(), $urandom()},
                da, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        exp_addr  = 40'h300;
        exp_wdata = 64'hCAFE;
        exp_wstrb = 8'h3C;
        launch(2'd1, 40'h300, 64'hCAFE, 8'h3C);
        chk("wreq_live", 64'({awvalid, wvalid}), 64'd3);
        rstn = 1'b0;
        #1;
        chk("rst_mid_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("rst_mid_status", 64'(status_out), 64'd0);
        chk("rst_mid_rdata", rdata_out, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_addr = '0;
        txn(2'd2, 40'hABC, 64'd0, 8'd0, 64'h77, 0, 0, 0, 1'b0);
        chk("lit_rst_addr", 64'(cap_addr), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
